// File: rtl/serial_wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package serial_wb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    // One-hot grant encodings presented on gnt_o
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/serial_wb_watchdog.sv
// Stall counter: counts consecutive stalled strobe cycles and flags the
// cycle in which the TIMEOUT-th consecutive stall occurs.
module serial_wb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic stall,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Count unbroken stall cycles; any non-stall cycle or state change restarts
    always_ff @(posedge clk) begin
        if (rst || clr || !stall) begin
            count <= '0;
        end else begin
            count <= count + TO_W'(1);
        end
    end

    // Expiry is flagged while the last allowed stall cycle is in progress, so
    // the abort state is entered exactly TIMEOUT cycles after the stall began;
    // a termination in that cycle clears stall and therefore wins.
    assign expired = stall && (count == LAST);

endmodule

// File: rtl/serial_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with bus lock and transfer watchdog.
module serial_wb_arbiter
    import serial_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_lock_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic             m1_lock_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic             s_lock_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    output logic [1:0]       gnt_o,
    output logic             timeout_o
);

    arb_state_t state, next;
    logic       last_gnt;     // 0: m0 was granted last, 1: m1
    logic       abort_fresh;  // high during the first ABORT cycle
    logic       stall;
    logic       expired;
    logic       sel1;
    logic       owner_cyc;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    serial_wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (next != state),
        .stall   (stall),
        .expired (expired)
    );

    // State register, round-robin history and abort first-cycle flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            abort_fresh <= 1'b0;
        end else begin
            state       <= next;
            abort_fresh <= (next == ABORT) && (state != ABORT);
            if (state == IDLE && next == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state == IDLE && next == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    // Next-state decode, slave-side muxing and termination routing
    always_comb begin
        next      = state;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_lock_o  = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_rty_o  = 1'b0;
        gnt_o     = GNT_NONE;
        timeout_o = 1'b0;
        stall     = 1'b0;
        sel1      = (state == GNT1);
        owner_cyc = last_gnt ? m1_cyc_i : m0_cyc_i;

        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    next = last_gnt ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    next = GNT0;
                end else if (m1_cyc_i) begin
                    next = GNT1;
                end
            end
            GNT0, GNT1: begin
                s_adr_o  = sel1 ? m1_adr_i  : m0_adr_i;
                s_dat_o  = sel1 ? m1_dat_i  : m0_dat_i;
                s_sel_o  = sel1 ? m1_sel_i  : m0_sel_i;
                s_cyc_o  = sel1 ? m1_cyc_i  : m0_cyc_i;
                s_stb_o  = sel1 ? m1_stb_i  : m0_stb_i;
                s_we_o   = sel1 ? m1_we_i   : m0_we_i;
                s_lock_o = sel1 ? m1_lock_i : m0_lock_i;
                gnt_o    = sel1 ? GNT_M1 : GNT_M0;
                // Terminations are suppressed while reset is asserted so a
                // mid-transfer reset never completes the transfer.
                if (!rst_i) begin
                    if (sel1) begin
                        m1_ack_o = s_ack_i;
                        m1_err_o = s_err_i;
                        m1_rty_o = s_rty_i;
                    end else begin
                        m0_ack_o = s_ack_i;
                        m0_err_o = s_err_i;
                        m0_rty_o = s_rty_i;
                    end
                end
                stall = s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
                if (expired) begin
                    next = ABORT;
                end else if (!s_cyc_o && !s_lock_o) begin
                    next = IDLE;
                end
            end
            ABORT: begin
                if (abort_fresh && !rst_i) begin
                    timeout_o = 1'b1;
                    if (last_gnt) begin
                        m1_err_o = 1'b1;
                    end else begin
                        m0_err_o = 1'b1;
                    end
                end
                if (!owner_cyc) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_wb_arbiter.sv
// Self-checking bench for serial_wb_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level arbitration model.
module tb_serial_wb_arbiter;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_cyc, m0_stb, m0_we, m0_lock;
    logic        m1_cyc, m1_stb, m1_we, m1_lock;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we, s_lock;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  gnt;
    logic        timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_wb_arbiter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_dat),
        .m0_sel_i  (m0_sel),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_lock_i (m0_lock),
        .m0_dat_o  (m0_rdat),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m0_rty_o  (m0_rty),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_dat),
        .m1_sel_i  (m1_sel),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_lock_i (m1_lock),
        .m1_dat_o  (m1_rdat),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .m1_rty_o  (m1_rty),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_sel_o   (s_sel),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_lock_o  (s_lock),
        .s_dat_i   (s_rdat),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rty_i   (s_rty),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle; inputs are then driven 1 ns after the edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet_inputs();
        {m0_cyc, m0_stb, m0_we, m0_lock} = '0;
        {m1_cyc, m1_stb, m1_we, m1_lock} = '0;
        {s_ack, s_err, s_rty} = '0;
        s_rdat = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    // Model state for the randomized phase
    logic [31:0] r_adr[2], r_dat[2];
    logic [3:0]  r_sel[2];
    logic        r_we[2];
    int          last_winner;
    int          mask, win, ws, kind;
    logic [2:0]  exp_term, win_term, lose_term;
    logic [31:0] rdata, win_rdat;

    initial begin
        rst = 1'b1;
        quiet_inputs();
        m0_adr = 32'h1234_5678; m0_dat = 32'hA5A5_0001; m0_sel = 4'hF;
        m1_adr = 32'h0;         m1_dat = 32'h0;         m1_sel = 4'h0;

        // Reset holds the bus idle even with m0 requesting and the slave acking
        m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv();
            check("rst_s_cyc", s_cyc, 0);
            check("rst_gnt", gnt, 2'b00);
            check("rst_s_adr", s_adr, 0);
            check("rst_m0_ack", m0_ack, 0);
            check("rst_timeout", timeout, 0);
        end
        rst = 1'b0; s_ack = 1'b0;
        settle();
        check("rst_rel_gnt", gnt, 2'b00);
        adv();
        check("rst_first_gnt", gnt, 2'b01);
        check("rst_first_cyc", s_cyc, 1);
        check("rst_first_adr", s_adr, 32'h1234_5678);

        // Contention: m0 first, then m1 after a dead cycle, then m0 again
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        adv();
        check("cont_c1_gnt", gnt, 2'b01);
        adv(); adv(); adv(); adv();
        m0_cyc = 1'b0;
        settle();
        check("cont_c5_gnt", gnt, 2'b01);
        adv();
        check("cont_c6_gnt", gnt, 2'b00);
        adv();
        check("cont_c7_gnt", gnt, 2'b10);
        adv();
        m1_cyc = 1'b0;
        adv();
        check("cont_c9_gnt", gnt, 2'b00);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        adv();
        check("cont_again_gnt", gnt, 2'b01);
        quiet_inputs();
        adv(); adv();

        // Lock holds the grant while cyc is low
        m0_cyc = 1'b1; m0_lock = 1'b1;
        adv();
        check("lock_gnt", gnt, 2'b01);
        m0_cyc = 1'b0; m1_cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adv();
            check("lock_hold_gnt", gnt, 2'b01);
            check("lock_s_cyc", s_cyc, 0);
        end
        m0_lock = 1'b0;
        adv();
        check("lock_rel_idle", gnt, 2'b00);
        adv();
        check("lock_rel_m1", gnt, 2'b10);
        quiet_inputs();
        adv(); adv();

        // Passthrough read by m1 with 3 wait states
        m1_adr = 32'h0000_0040; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
        adv();
        check("pt_gnt", gnt, 2'b10);
        check("pt_s_adr", s_adr, 32'h0000_0040);
        check("pt_s_we", s_we, 0);
        check("pt_s_stb", s_stb, 1);
        for (int i = 0; i < 3; i++) begin
            check("pt_wait_ack", m1_ack, 0);
            adv();
        end
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        settle();
        check("pt_m1_ack", m1_ack, 1);
        check("pt_m1_dat", m1_rdat, 32'hDEAD_BEEF);
        check("pt_m0_ack", m0_ack, 0);
        adv();
        quiet_inputs();
        settle();
        check("pt_ack_pulse", m1_ack, 0);
        adv(); adv();

        // Watchdog abort after TIMEOUT stalled cycles
        m0_cyc = 1'b1;
        adv();
        check("to_gnt", gnt, 2'b01);
        m0_stb = 1'b1;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            settle();
            check("to_stall_err", m0_err, 0);
            check("to_stall_to", timeout, 0);
            check("to_stall_cyc", s_cyc, 1);
            adv();
        end
        check("to_err", m0_err, 1);
        check("to_pulse", timeout, 1);
        check("to_s_cyc", s_cyc, 0);
        check("to_gnt_none", gnt, 2'b00);
        m1_cyc = 1'b1;
        adv();
        s_ack = 1'b1;
        settle();
        check("to_err_once", m0_err, 0);
        check("to_pulse_once", timeout, 0);
        check("to_ack_ignored", m0_ack, 0);
        check("to_stb_low", s_stb, 0);
        adv();
        s_ack = 1'b0;
        check("to_hold_gnt", gnt, 2'b00);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        adv();
        check("to_idle_gnt", gnt, 2'b00);
        adv();
        check("to_next_gnt", gnt, 2'b10);
        quiet_inputs();
        adv(); adv();

        // Termination on the final allowed stall cycle wins over the abort
        m0_cyc = 1'b1;
        adv();
        m0_stb = 1'b1;
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
            adv();
        end
        s_ack = 1'b1;
        settle();
        check("bnd_ack", m0_ack, 1);
        check("bnd_err", m0_err, 0);
        check("bnd_to", timeout, 0);
        adv();
        s_ack = 1'b0; m0_stb = 1'b0;
        settle();
        check("bnd_after_err", m0_err, 0);
        check("bnd_after_to", timeout, 0);
        check("bnd_after_gnt", gnt, 2'b01);
        quiet_inputs();
        adv(); adv();

        // Randomized transactions against a transaction-level model
        do_reset();
        last_winner = 1;
        for (int it = 0; it < 30; it++) begin
            mask = int'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                r_adr[m] = $urandom;
                r_dat[m] = $urandom;
                r_sel[m] = 4'($urandom);
                r_we[m]  = 1'($urandom);
            end
            m0_adr = r_adr[0]; m0_dat = r_dat[0]; m0_sel = r_sel[0]; m0_we = r_we[0];
            m1_adr = r_adr[1]; m1_dat = r_dat[1]; m1_sel = r_sel[1]; m1_we = r_we[1];
            m0_cyc = mask[0]; m0_stb = mask[0];
            m1_cyc = mask[1]; m1_stb = mask[1];
            if (mask == 3) win = 1 - last_winner;
            else           win = (mask == 1) ? 0 : 1;
            adv();
            check("rnd_gnt", gnt, (win == 0) ? 2'b01 : 2'b10);
            check("rnd_s_adr", s_adr, r_adr[win]);
            check("rnd_s_dat", s_wdat, r_dat[win]);
            check("rnd_s_sel", s_sel, r_sel[win]);
            check("rnd_s_we", s_we, r_we[win]);
            ws = int'($urandom_range(0, 5));
            for (int w = 0; w < ws; w++) begin
                win_term = (win == 0) ? {m0_ack, m0_err, m0_rty} : {m1_ack, m1_err, m1_rty};
                check("rnd_wait_term", win_term, 0);
                adv();
            end
            kind = int'($urandom_range(0, 2));
            rdata = $urandom;
            s_rdat = rdata;
            s_ack = (kind == 0); s_err = (kind == 1); s_rty = (kind == 2);
            exp_term = 3'b100 >> kind;
            settle();
            win_term  = (win == 0) ? {m0_ack, m0_err, m0_rty} : {m1_ack, m1_err, m1_rty};
            lose_term = (win == 0) ? {m1_ack, m1_err, m1_rty} : {m0_ack, m0_err, m0_rty};
            win_rdat  = (win == 0) ? m0_rdat : m1_rdat;
            check("rnd_win_term", win_term, exp_term);
            check("rnd_lose_term", lose_term, 0);
            check("rnd_rdat", win_rdat, rdata);
            last_winner = win;
            adv();
            quiet_inputs();
            adv();
            check("rnd_release", gnt, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_wb_arbiter.md
# serial_wb_arbiter

Two-master Wishbone arbiter that shares one Wishbone slave bus between the serial debug controller's master port (m0) and a second on-chip master such as a capture/DMA engine (m1). It sits between both masters and the system interconnect. It does fair round-robin grant, honours bus lock and runs a per-transfer watchdog. The watchdog aborts a stalled slave with an error so the debug path can never hang.

## Interface
Parameters:
- TIMEOUT, 255: consecutive stalled strobe cycles before abort; legal 2..2^TO_W-1.
- TO_W, 8: watchdog counter width.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- mN_adr_i / mN_dat_i  input  32 each (N=0,1)  master address / write data.
- mN_sel_i  input  4  byte selects.
- mN_cyc_i, mN_stb_i, mN_we_i, mN_lock_i  input  1 each  master cycle controls.
- mN_dat_o  output  32  read data; s_dat_i broadcast to both masters.
- mN_ack_o, mN_err_o, mN_rty_o  output  1 each  terminations, granted master only.
- s_adr_o / s_dat_o  output  32 each  to slave.
- s_sel_o  output  4.
- s_cyc_o, s_stb_o, s_we_o, s_lock_o  output  1 each.
- s_dat_i  input  32; s_ack_i, s_err_i, s_rty_i  input  1 each.
- gnt_o  output  2  one-hot current grant; 00 when idle or aborting.
- timeout_o  output  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, GNT0, GNT1, ABORT. Register last_gnt, reset to 1, so m0 wins the first contention.
- IDLE:
  - Only one mN_cyc_i high: go to GNTN.
  - Both high: grant the master that is not last_gnt.
  - All s_* outputs are 0 and all mN terminations are 0.
- GNTN:
  - s_adr/dat/sel/cyc/stb/we/lock_o are driven combinationally from master N.
  - s_ack/err/rty_i pass combinationally to mN_*_o.
  - The other master's terminations are held 0.
  - last_gnt <= N on entry.
- Release: in GNTN with mN_cyc_i=0 and mN_lock_i=0, go to IDLE. If lock is high, the grant is held even with cyc low.
- Watchdog:
  - Counter increments in GNTN while s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - It clears on any termination, on s_stb_o=0, and on every state change.
  - When the count reaches TIMEOUT, go to ABORT.
- ABORT:
  - First cycle: mN_err_o=1 and timeout_o=1.
  - s_cyc_o=s_stb_o=0 for the whole state.
  - Slave terminations are ignored.
  - Stay until mN_cyc_i=0, ignoring lock, then go to IDLE.
- Reset (synchronous): state goes to IDLE, counter to 0, last_gnt to 1. A mid-transfer reset drops s_cyc_o at the next edge with no termination issued.

## Timing
- Reset values: every output is 0; gnt_o=00.
- Grant latency:
  - Master raises cyc in cycle t while state is IDLE.
  - Cycle t+1: GNTN, s_cyc_o=1, gnt_o updated.
- Terminations are zero-latency combinational slave→master in GNTN. A single classic cycle costs 1 arbitration cycle plus slave latency.
- Handover:
  - Owner drops cyc (lock low) in cycle t.
  - Cycle t+1: IDLE.
  - Cycle t+2: earliest grant to the waiting master. There is always one dead cycle.
- Timeout:
  - Stall starts at cycle t and is unbroken through t+TIMEOUT-1.
  - Cycle t+TIMEOUT: ABORT, mN_err_o and timeout_o high for exactly one cycle, s_cyc_o low.
- A termination arriving in the same cycle the counter would reach TIMEOUT wins: it is passed through and no abort occurs.

## Structure
- Shared package serial_wb_pkg holds:
  - the arb_state_t enum (IDLE, GNT0, GNT1, ABORT);
  - the grant encodings;
  - the Wishbone width constants (ADR_W=32, DAT_W=32, SEL_W=4).
- One sub-module, serial_wb_watchdog: a TO_W-bit stall counter with inputs clr/stall and output expired.
- Grant FSM and muxing live in serial_wb_arbiter.

## Test plan
- **Reset:** m0 cyc/stb high with rst_i=1 for 3 cycles → s_cyc_o=0, gnt_o=00. Release reset → gnt_o=01 on the next cycle.
- **Contention:** both masters request at cycle 0 → m0 granted at cycle 1. m0 drops cyc at cycle 5 → IDLE at 6, m1 granted at 7. Repeat → m0 is granted before m1 again, confirming alternation.
- **Lock:** m0 with lock=1 drops cyc for 4 cycles while m1 requests → gnt_o stays 01. Lock falls → m1 granted 2 cycles later.
- **Passthrough:** m1 reads address 0x0000_0040; slave acks with 0xDEADBEEF after 3 wait states → m1_ack_o is a 1-cycle pulse with m1_dat_o=0xDEADBEEF, and m0_ack_o stays 0.
- **Timeout:** TIMEOUT=8 and the slave never responds → m0_err_o and timeout_o pulse exactly 8 cycles after stb rises, with s_cyc_o low that cycle. Next grant is possible only after m0 drops cyc.
- **Boundary:** ack arrives on stall cycle 8 with TIMEOUT=8 → ack is delivered, no err, no timeout_o.
